// File: rtl/cmp_result_tracker.sv
// ---------------------------------------------------------------------------
// cmp_result_tracker
//
// Collects comparator results (A>B / A==B / A<B flags plus operand A) over a
// window of WINDOW accepted samples and presents one report per window:
// per-class counts, the number of samples, and the largest A seen. A window
// can be closed early with flush. The report is held until the consumer
// accepts it.
//
// Parameters
//   WINDOW        samples per report window, legal range 1..15
//
// Ports
//   clk           clock, rising-edge active
//   rst_n         asynchronous active-low reset
//   A             operand A of the current sample (4 bits)
//   A_greater     comparator flag A>B for the current sample
//   A_equal       comparator flag A==B for the current sample
//   A_less        comparator flag A<B for the current sample
//   in_valid      current sample is valid
//   in_ready      block can accept a sample (low while a report is held)
//   flush         close the current window early
//   out_gt_cnt    count of "greater" samples in the window
//   out_eq_cnt    count of "equal" samples in the window
//   out_lt_cnt    count of "less" samples in the window
//   out_n         number of samples accepted in the window
//   out_max_a     largest A accepted in the window
//   err           malformed-flag indicator (sticky until report accepted)
//   out_valid     report is valid
//   out_ready     consumer accepts the report
//
// Configuration macro
//   CMP_TRACK_ERRCHK_EN  when defined, samples whose flags are not exactly
//                        one-hot are counted in out_n/out_max_a only and set
//                        err. When undefined, flags are resolved by priority
//                        greater > less > equal (none set counts as equal)
//                        and err is tied low.
// ---------------------------------------------------------------------------
module cmp_result_tracker #(
    parameter int WINDOW = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] A,
    input  logic       A_greater,
    input  logic       A_equal,
    input  logic       A_less,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       flush,
    output logic [3:0] out_gt_cnt,
    output logic [3:0] out_eq_cnt,
    output logic [3:0] out_lt_cnt,
    output logic [3:0] out_n,
    output logic [3:0] out_max_a,
    output logic       err,
    output logic       out_valid,
    input  logic       out_ready
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        REPORT
    } state_t;

    localparam logic [3:0] WIN = 4'(WINDOW);

    state_t     state_q, state_d;
    logic [3:0] gtCnt_q, gtCnt_d;
    logic [3:0] eqCnt_q, eqCnt_d;
    logic [3:0] ltCnt_q, ltCnt_d;
    logic [3:0] nCnt_q, nCnt_d;
    logic [3:0] maxA_q, maxA_d;

    logic xfer;
    logic isGt;
    logic isEq;
    logic isLt;

    assign in_ready  = (state_q != REPORT);
    assign out_valid = (state_q == REPORT);
    assign xfer      = in_valid & in_ready;

`ifdef CMP_TRACK_ERRCHK_EN
    // Only an exactly one-hot flag set is classified; anything else is
    // malformed and lands in no class.
    logic isBad;
    logic err_q, err_d;

    always_comb begin
        isGt  = 1'b0;
        isEq  = 1'b0;
        isLt  = 1'b0;
        isBad = 1'b0;
        case ({A_greater, A_equal, A_less})
            3'b100:  isGt  = 1'b1;
            3'b010:  isEq  = 1'b1;
            3'b001:  isLt  = 1'b1;
            default: isBad = 1'b1;
        endcase
    end

    // Sticky error: set by any malformed accepted sample, cleared only when
    // the report carrying it is taken by the consumer.
    always_comb begin
        err_d = err_q;
        if (state_q == REPORT && out_ready) begin
            err_d = 1'b0;
        end else if (xfer && isBad) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    // Priority resolution: greater wins, then less; an all-zero or any
    // remaining pattern falls through to equal.
    always_comb begin
        isGt = A_greater;
        isLt = ~A_greater & A_less;
        isEq = ~A_greater & ~A_less;
    end

    assign err = 1'b0;
`endif

    // Next-state and counter update. Counters never wrap because WINDOW is
    // at most 15. A flush in ACCUM closes the window after counting any
    // sample transferred in the same cycle; flush elsewhere is ignored.
    always_comb begin
        state_d = state_q;
        gtCnt_d = gtCnt_q;
        eqCnt_d = eqCnt_q;
        ltCnt_d = ltCnt_q;
        nCnt_d  = nCnt_q;
        maxA_d  = maxA_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    gtCnt_d = {3'b000, isGt};
                    eqCnt_d = {3'b000, isEq};
                    ltCnt_d = {3'b000, isLt};
                    nCnt_d  = 4'd1;
                    maxA_d  = A;
                    state_d = (WIN == 4'd1) ? REPORT : ACCUM;
                end
            end
            ACCUM: begin
                if (xfer) begin
                    gtCnt_d = gtCnt_q + {3'b000, isGt};
                    eqCnt_d = eqCnt_q + {3'b000, isEq};
                    ltCnt_d = ltCnt_q + {3'b000, isLt};
                    nCnt_d  = nCnt_q + 4'd1;
                    maxA_d  = (A > maxA_q) ? A : maxA_q;
                end
                if ((xfer && (nCnt_q + 4'd1) == WIN) || flush) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (out_ready) begin
                    gtCnt_d = 4'd0;
                    eqCnt_d = 4'd0;
                    ltCnt_d = 4'd0;
                    nCnt_d  = 4'd0;
                    maxA_d  = 4'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and report registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gtCnt_q <= 4'd0;
            eqCnt_q <= 4'd0;
            ltCnt_q <= 4'd0;
            nCnt_q  <= 4'd0;
            maxA_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            gtCnt_q <= gtCnt_d;
            eqCnt_q <= eqCnt_d;
            ltCnt_q <= ltCnt_d;
            nCnt_q  <= nCnt_d;
            maxA_q  <= maxA_d;
        end
    end

    assign out_gt_cnt = gtCnt_q;
    assign out_eq_cnt = eqCnt_q;
    assign out_lt_cnt = ltCnt_q;
    assign out_n      = nCnt_q;
    assign out_max_a  = maxA_q;

endmodule

// File: tb/tb_cmp_result_tracker.sv
// ---------------------------------------------------------------------------
// tb_cmp_result_tracker
//
// Directed bench for cmp_result_tracker. A WINDOW=4 instance carries most
// scenarios; a WINDOW=1 instance shares the sample inputs but has its own
// in_valid/out_ready so it only sees its own scenario. Inputs change 1 time
// unit after each rising edge and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_cmp_result_tracker;

    logic       clk;
    logic       rst_n;
    logic [3:0] A;
    logic       aGreater;
    logic       aEqual;
    logic       aLess;
    logic       inValid;
    logic       flush;
    logic       outReady;

    logic       inReady;
    logic [3:0] gtCnt;
    logic [3:0] eqCnt;
    logic [3:0] ltCnt;
    logic [3:0] nCnt;
    logic [3:0] maxA;
    logic       errOut;
    logic       outValid;

    logic       inValid1;
    logic       outReady1;
    logic       inReady1;
    logic [3:0] gtCnt1;
    logic [3:0] eqCnt1;
    logic [3:0] ltCnt1;
    logic [3:0] nCnt1;
    logic [3:0] maxA1;
    logic       errOut1;
    logic       outValid1;

    int errors;
    int checks;

    cmp_result_tracker #(.WINDOW(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .A          (A),
        .A_greater  (aGreater),
        .A_equal    (aEqual),
        .A_less     (aLess),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .flush      (flush),
        .out_gt_cnt (gtCnt),
        .out_eq_cnt (eqCnt),
        .out_lt_cnt (ltCnt),
        .out_n      (nCnt),
        .out_max_a  (maxA),
        .err        (errOut),
        .out_valid  (outValid),
        .out_ready  (outReady)
    );

    cmp_result_tracker #(.WINDOW(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .A          (A),
        .A_greater  (aGreater),
        .A_equal    (aEqual),
        .A_less     (aLess),
        .in_valid   (inValid1),
        .in_ready   (inReady1),
        .flush      (flush),
        .out_gt_cnt (gtCnt1),
        .out_eq_cnt (eqCnt1),
        .out_lt_cnt (ltCnt1),
        .out_n      (nCnt1),
        .out_max_a  (maxA1),
        .err        (errOut1),
        .out_valid  (outValid1),
        .out_ready  (outReady1)
    );

    // 10-unit free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one sample onto the shared inputs of the WINDOW=4 instance.
    task automatic applyStimulus(input logic [3:0] a, input logic g,
                                 input logic e, input logic l,
                                 input logic v, input logic f);
        A        = a;
        aGreater = g;
        aEqual   = e;
        aLess    = l;
        inValid  = v;
        flush    = f;
    endtask

    // Advance to just after the next rising edge.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // One comparison: counts it, and counts/report a failure.
    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Check the full report of the WINDOW=4 instance.
    task automatic checkReport(input string tag, input logic v,
                               input logic [3:0] g, input logic [3:0] e,
                               input logic [3:0] l, input logic [3:0] n,
                               input logic [3:0] m);
        checkOutput({tag, ".out_valid"}, {7'd0, outValid}, {7'd0, v});
        checkOutput({tag, ".gt"}, {4'd0, gtCnt}, {4'd0, g});
        checkOutput({tag, ".eq"}, {4'd0, eqCnt}, {4'd0, e});
        checkOutput({tag, ".lt"}, {4'd0, ltCnt}, {4'd0, l});
        checkOutput({tag, ".n"}, {4'd0, nCnt}, {4'd0, n});
        checkOutput({tag, ".max_a"}, {4'd0, maxA}, {4'd0, m});
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        outReady  = 1'b0;
        inValid1  = 1'b0;
        outReady1 = 1'b1;
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state
        stepClock();
        stepClock();
        checkReport("reset", 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        checkOutput("reset.err", {7'd0, errOut}, 8'd0);
        rst_n = 1'b1;
        stepClock();
        checkOutput("reset.in_ready", {7'd0, inReady}, 8'd1);

        // Flush in IDLE without a sample is ignored
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        stepClock();
        checkReport("idleflush", 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);

        // Full window: 5/gt, 8/eq, 2/lt, 15/gt
        $display("[TB] full window");
        applyStimulus(4'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        stepClock();
        checkReport("acc1", 1'b0, 4'd1, 4'd0, 4'd0, 4'd1, 4'd5);
        applyStimulus(4'd8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        stepClock();
        applyStimulus(4'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        stepClock();
        checkOutput("acc3.in_ready", {7'd0, inReady}, 8'd1);
        applyStimulus(4'd15, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        stepClock();
        checkReport("full", 1'b1, 4'd2, 4'd1, 4'd1, 4'd4, 4'd15);
        checkOutput("full.in_ready", {7'd0, inReady}, 8'd0);

        // Hold the report with out_ready low while samples are offered
        $display("[TB] report hold");
        applyStimulus(4'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            stepClock();
            checkReport("hold", 1'b1, 4'd2, 4'd1, 4'd1, 4'd4, 4'd15);
        end
        outReady = 1'b1;
        stepClock();
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        outReady = 1'b0;
        checkReport("drain", 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        checkOutput("drain.in_ready", {7'd0, inReady}, 8'd1);

        // Early close: flush together with the third sample
        $display("[TB] flush");
        applyStimulus(4'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        stepClock();
        applyStimulus(4'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        stepClock();
        applyStimulus(4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        stepClock();
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkReport("flush", 1'b1, 4'd1, 4'd1, 4'd1, 4'd3, 4'd9);
        outReady = 1'b1;
        stepClock();
        outReady = 1'b0;
        checkOutput("flush.drain", {7'd0, outValid}, 8'd0);

        // Asynchronous reset in the middle of a window
        $display("[TB] mid-window reset");
        applyStimulus(4'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        stepClock();
        applyStimulus(4'd12, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        stepClock();
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("prereset.n", {4'd0, nCnt}, 8'd2);
        #2;
        rst_n = 1'b0;
        #1;
        checkReport("asyncrst", 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        stepClock();
        rst_n = 1'b1;
        applyStimulus(4'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        stepClock();
        applyStimulus(4'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        stepClock();
        applyStimulus(4'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        stepClock();
        applyStimulus(4'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        stepClock();
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkReport("postrst", 1'b1, 4'd0, 4'd1, 4'd3, 4'd4, 4'd4);
        outReady = 1'b1;
        stepClock();
        outReady = 1'b0;

        // Malformed flags: A_greater and A_less both set
        $display("[TB] malformed flags");
        applyStimulus(4'd10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        stepClock();
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef CMP_TRACK_ERRCHK_EN
        checkReport("bad", 1'b0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd10);
        checkOutput("bad.err", {7'd0, errOut}, 8'd1);
        flush = 1'b1;
        stepClock();
        flush = 1'b0;
        checkOutput("bad.report_err", {7'd0, errOut}, 8'd1);
        checkOutput("bad.report_valid", {7'd0, outValid}, 8'd1);
        outReady = 1'b1;
        stepClock();
        outReady = 1'b0;
        checkOutput("bad.err_clear", {7'd0, errOut}, 8'd0);
`else
        checkReport("bad", 1'b0, 4'd1, 4'd0, 4'd0, 4'd1, 4'd10);
        checkOutput("bad.err", {7'd0, errOut}, 8'd0);
        flush = 1'b1;
        stepClock();
        flush = 1'b0;
        checkOutput("bad.report_valid", {7'd0, outValid}, 8'd1);
        outReady = 1'b1;
        stepClock();
        outReady = 1'b0;
        checkOutput("bad.drain", {7'd0, outValid}, 8'd0);
`endif

        // WINDOW=1 instance: single sample 7/eq
        $display("[TB] window of one");
        checkOutput("w1.idle_valid", {7'd0, outValid1}, 8'd0);
        outReady1 = 1'b0;
        applyStimulus(4'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        inValid1 = 1'b1;
        stepClock();
        inValid1 = 1'b0;
        checkOutput("w1.out_valid", {7'd0, outValid1}, 8'd1);
        checkOutput("w1.n", {4'd0, nCnt1}, 8'd1);
        checkOutput("w1.eq", {4'd0, eqCnt1}, 8'd1);
        checkOutput("w1.gt", {4'd0, gtCnt1}, 8'd0);
        checkOutput("w1.lt", {4'd0, ltCnt1}, 8'd0);
        checkOutput("w1.max_a", {4'd0, maxA1}, 8'd7);
        checkOutput("w1.in_ready", {7'd0, inReady1}, 8'd0);
        checkOutput("w1.err", {7'd0, errOut1}, 8'd0);
        outReady1 = 1'b1;
        stepClock();
        checkOutput("w1.drain", {7'd0, outValid1}, 8'd0);
        checkOutput("w1.drain_n", {4'd0, nCnt1}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmp_result_tracker.md
CMP_RESULT_TRACKER -- requirements
Module: cmp_result_tracker

Interface
REQ-001 The block SHALL have parameter WINDOW, default 8, legal range 1..15: number of accepted samples per report window.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port A, input, 4 bits: operand A of the current sample.
REQ-005 The block SHALL have port A_greater, input, 1 bit: comparator flag A>B for the current sample.
REQ-006 The block SHALL have port A_equal, input, 1 bit: comparator flag A==B for the current sample.
REQ-007 The block SHALL have port A_less, input, 1 bit: comparator flag A<B for the current sample.
REQ-008 The block SHALL have port in_valid, input, 1 bit: the current sample is valid.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block can accept a sample.
REQ-010 The block SHALL have port flush, input, 1 bit: close the current window early.
REQ-011 The block SHALL have ports out_gt_cnt, out_eq_cnt and out_lt_cnt, each output, 4 bits: per-class counts for the window.
REQ-012 The block SHALL have port out_n, output, 4 bits: number of samples accepted in the window.
REQ-013 The block SHALL have port out_max_a, output, 4 bits: largest A accepted in the window.
REQ-014 The block SHALL have port err, output, 1 bit: malformed-flag indicator (see REQ-029).
REQ-015 The block SHALL have port out_valid, output, 1 bit: the report is valid.
REQ-016 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the report.

Function
REQ-017 Accept: a sample SHALL transfer on a rising clk edge only when in_valid=1 and in_ready=1.
REQ-018 FSM states SHALL be IDLE (no samples), ACCUM (1..WINDOW-1 samples) and REPORT (report held).
REQ-019 in_ready SHALL be 1 in IDLE and ACCUM, 0 in REPORT; out_valid SHALL be 1 only in REPORT.
REQ-020 IDLE->ACCUM SHALL occur on a transfer when WINDOW>1; IDLE->REPORT SHALL occur on a transfer when WINDOW=1.
REQ-021 ACCUM->REPORT SHALL occur on the transfer that makes the sample count equal WINDOW (one-cycle latency: out_valid=1 in the following cycle).
REQ-022 flush=1 in ACCUM SHALL force REPORT next cycle with the partial counts; a transfer in the same cycle SHALL be counted before closing.
REQ-023 flush in IDLE (with or without a transfer) and flush in REPORT SHALL be ignored; an IDLE flush with a transfer SHALL count the sample normally.
REQ-024 Classification priority SHALL be A_greater > A_less > A_equal; a sample with no flag set SHALL count as equal (macro off).
REQ-025 out_max_a SHALL be updated with max(current, A) on each transfer; the first sample of a window SHALL load A directly.
REQ-026 In REPORT, all out_* SHALL hold stable until out_valid & out_ready; the block SHALL then enter IDLE with counts, out_n and out_max_a cleared to 0.
REQ-027 Counters SHALL never wrap, because WINDOW<=15 bounds every count.

Reset
REQ-028 While rst_n=0, the state SHALL be IDLE; all counts, out_n, out_max_a, err and out_valid SHALL be 0; in_ready SHALL be 1 after release. A reset mid-window or mid-report SHALL discard that window.

Configuration
REQ-029 Macro CMP_TRACK_ERRCHK_EN SHALL control malformed-flag checking.
- Defined: a sample whose flags are not exactly one-hot SHALL count in out_n and out_max_a but in no class, and SHALL set err sticky until the report is accepted or rst_n=0.
- Undefined: REQ-024 applies and err SHALL be tied to 0.

Verification
REQ-030 The bench SHALL run the following directed scenarios, with WINDOW=4 unless stated.
- Four samples A=5/gt, 8/eq, 2/lt, 15/gt -> cycle after 4th accept: out_valid=1, gt=2, eq=1, lt=1, n=4, max_a=15, in_ready=0.
- Report held with out_ready=0 for 5 cycles, in_valid=1 -> outputs unchanged, no sample accepted; out_ready=1 -> IDLE, counts 0, in_ready=1.
- Two samples (A=3/lt, A=9/gt), then flush together with third sample A=1/eq -> n=3, gt=1, eq=1, lt=1, max_a=9.
- rst_n pulsed low after two samples -> all outputs 0 immediately (async); next report contains only post-reset samples.
- Macro on, sample with A_greater=1 and A_less=1 -> err=1, counted in n only; macro off -> counted gt, err=0.
- WINDOW=1, single sample A=7/eq -> out_valid next cycle, n=1, eq=1, max_a=7.
